mlp_pipeline_sequencer: RTL

Parametrised inter-layer sequencer for chained fc_layer MLPs, replacing hand-wired per-layer top-level ports. It accepts an external input stream and loads layer 0's input buffer, then forwards each layer's func output stream into the next layer's input buffer. It also generates start pulses and next-busy backpressure, and emits the final layer's outputs as a stream with a frame-done pulse.

---
 rtl/mlp_seq_pkg.sv | 32 +++
 rtl/mlp_pipeline_sequencer_link.sv | 87 ++++++++
 rtl/mlp_pipeline_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/mlp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_seq_pkg
//  Description : Shared types, default sizes and helpers for the MLP
//                inter-layer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mlp_seq_pkg;

    // Per-link sequencing state
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARM   = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } link_state_t;

    // Default network geometry
    localparam int C_DEF_NUM_LAYERS    = 5;
    localparam int C_DEF_DATATYPE_SIZE = 4;
    localparam int C_DEF_MAX_SIZE      = 1500;
    localparam int C_DEF_OUT_SIZE      = 10;
    localparam int C_DEF_LAYER_IN_SIZE [C_DEF_NUM_LAYERS] = '{784, 784, 1500, 1000, 500};

    // Address width for a buffer of max_size elements (never below one bit)
    function automatic int addr_w_f(input int max_size);
        return (max_size > 1) ? $clog2(max_size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_pipeline_sequencer_link.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_link
//  Description : One inter-layer link: fills a layer's input buffer from a
//                source stream, then hands the frame to the layer with a
//                start pulse and tracks the layer's busy handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_link
    import mlp_seq_pkg::*;
#(
    parameter int DATATYPE_SIZE = 4,
    parameter int ADDR_W        = 11,
    parameter int IN_SIZE       = 784
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_src_valid,
    input  logic [DATATYPE_SIZE-1:0] i_src_data,
    input  logic                     i_busy,
    output logic                     o_accepting,
    output logic                     o_active,
    output logic                     o_ibuf_we,
    output logic [ADDR_W-1:0]        o_ibuf_addr,
    output logic [DATATYPE_SIZE-1:0] o_ibuf_wr_data,
    output logic                     o_start
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(IN_SIZE - 1);

    link_state_t         r_state;
    logic [ADDR_W-1:0]   r_wcnt;
    logic                w_accept;

    assign o_accepting = (r_state == IDLE) || (r_state == FILL);
    assign o_active    = (r_state == ARM) || (r_state == RUN) || (r_state == DRAIN);
    assign w_accept    = o_accepting && i_src_valid;

    // The layer may only be started once it has finished any previous frame;
    // reset suppresses the pulse even if the state has not yet cleared.
    assign o_start     = (r_state == ARM) && !i_busy && !rst;

    // Link FSM, fill counter and registered input-buffer write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_wcnt         <= '0;
            o_ibuf_we      <= 1'b0;
            o_ibuf_addr    <= '0;
            o_ibuf_wr_data <= '0;
        end else begin
            o_ibuf_we <= w_accept;
            if (w_accept) begin
                o_ibuf_addr    <= r_wcnt;
                o_ibuf_wr_data <= i_src_data;
            end
            case (r_state)
                IDLE, FILL: begin
                    if (w_accept) begin
                        if (r_wcnt == C_LAST) begin
                            r_state <= ARM;
                            r_wcnt  <= '0;
                        end else begin
                            r_state <= FILL;
                            r_wcnt  <= r_wcnt + ADDR_W'(1);
                        end
                    end
                end
                ARM: begin
                    if (!i_busy) r_state <= RUN;
                end
                RUN: begin
                    if (i_busy) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!i_busy) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mlp_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_pipeline_sequencer
//  Description : Sequencer for a chain of fc layers. Routes the external
//                stream into layer 0 and each layer's func stream into the
//                next layer, generates start/backpressure, flags dropped
//                elements and streams out the final layer with frame markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_pipeline_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int NUM_LAYERS                  = C_DEF_NUM_LAYERS,
    parameter int DATATYPE_SIZE               = C_DEF_DATATYPE_SIZE,
    parameter int MAX_SIZE                    = C_DEF_MAX_SIZE,
    parameter int LAYER_IN_SIZE [NUM_LAYERS]  = C_DEF_LAYER_IN_SIZE,
    parameter int OUT_SIZE                    = C_DEF_OUT_SIZE,
    localparam int ADDR_W                     = addr_w_f(MAX_SIZE)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_in_valid,
    input  logic [DATATYPE_SIZE-1:0]                 i_in_data,
    output logic                                     o_in_ready,
    output logic [NUM_LAYERS-1:0]                    o_ibuf_we,
    output logic [NUM_LAYERS-1:0][ADDR_W-1:0]        o_ibuf_addr,
    output logic [NUM_LAYERS-1:0][DATATYPE_SIZE-1:0] o_ibuf_wr_data,
    output logic [NUM_LAYERS-1:0]                    o_start,
    input  logic [NUM_LAYERS-1:0]                    i_busy,
    input  logic [NUM_LAYERS-1:0]                    i_func_valid,
    input  logic [NUM_LAYERS-1:0][DATATYPE_SIZE-1:0] i_func_data,
    output logic [NUM_LAYERS-1:0]                    o_next_busy,
    output logic                                     o_out_valid,
    output logic [DATATYPE_SIZE-1:0]                 o_out_data,
    input  logic                                     i_out_ready,
    output logic                                     o_frame_done,
    output logic [NUM_LAYERS-1:0]                    o_overflow
);

    localparam logic [ADDR_W-1:0] C_OUT_LAST = ADDR_W'(OUT_SIZE - 1);

    logic [NUM_LAYERS-1:0]                    w_src_valid;
    logic [NUM_LAYERS-1:0][DATATYPE_SIZE-1:0] w_src_data;
    logic [NUM_LAYERS-1:0]                    w_accepting;
    logic [NUM_LAYERS-1:0]                    w_active;
    logic [ADDR_W-1:0]                        r_ocnt;

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_link
        if (k == 0) begin : g_src_ext
            assign w_src_valid[k] = i_in_valid;
            assign w_src_data[k]  = i_in_data;
        end else begin : g_src_func
            assign w_src_valid[k] = i_func_valid[k-1];
            assign w_src_data[k]  = i_func_data[k-1];
        end

        mlp_link #(
            .DATATYPE_SIZE (DATATYPE_SIZE),
            .ADDR_W        (ADDR_W),
            .IN_SIZE       (LAYER_IN_SIZE[k])
        ) u_link (
            .clk            (clk),
            .rst            (rst),
            .i_src_valid    (w_src_valid[k]),
            .i_src_data     (w_src_data[k]),
            .i_busy         (i_busy[k]),
            .o_accepting    (w_accepting[k]),
            .o_active       (w_active[k]),
            .o_ibuf_we      (o_ibuf_we[k]),
            .o_ibuf_addr    (o_ibuf_addr[k]),
            .o_ibuf_wr_data (o_ibuf_wr_data[k]),
            .o_start        (o_start[k])
        );

        // A layer must stall its func stream while the next link holds a
        // frame; the last layer is stalled by the downstream consumer.
        if (k < NUM_LAYERS - 1) begin : g_nb_link
            assign o_next_busy[k] = w_active[k+1];
        end else begin : g_nb_out
            assign o_next_busy[k] = ~i_out_ready;
        end
    end

    assign o_in_ready = w_accepting[0];

    // Sticky overflow: a func element arriving at a link that cannot take it
    // is dropped and remembered until reset. Link 0 is flow-controlled by
    // o_in_ready, so its flag never sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_overflow <= '0;
        end else begin
            for (int k = 1; k < NUM_LAYERS; k++) begin
                if (i_func_valid[k-1] && !w_accepting[k]) o_overflow[k] <= 1'b1;
            end
        end
    end

    // Output stage: one-cycle registered copy of the last layer's stream
    // with a modulo-OUT_SIZE element counter marking frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_out_valid  <= 1'b0;
            o_out_data   <= '0;
            o_frame_done <= 1'b0;
            r_ocnt       <= '0;
        end else begin
            o_out_valid  <= i_func_valid[NUM_LAYERS-1];
            o_frame_done <= i_func_valid[NUM_LAYERS-1] && (r_ocnt == C_OUT_LAST);
            if (i_func_valid[NUM_LAYERS-1]) begin
                o_out_data <= i_func_data[NUM_LAYERS-1];
                r_ocnt     <= (r_ocnt == C_OUT_LAST) ? '0 : r_ocnt + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
